router_ctrl: RTL and testbench

ROUTER_CTRL -- requirements
Module: router_ctrl

---
 rtl/router_pkg.sv | 50 +++++
 rtl/router_sr_timer.sv | 52 +++++
 rtl/router_ctrl.sv | 177 +++++++++++++++++
 tb/tb_router_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router control slice.
//   state_t          - controller FSM state encoding
//   ADDR0..ADDR2     - valid destination codes, ADDR_INVALID = 3
//   TIMEOUT_DEFAULT  - default read-idle cycles before a channel soft reset
//   sel_bit()        - pick one bit of a 3-bit per-channel vector by address
//   addr_onehot()    - one-hot decode of a destination address
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    localparam int TIMEOUT_DEFAULT = 30;

    // The invalid address selects no channel, so it reads as 0 here.
    function automatic logic sel_bit(input logic [2:0] vec, input logic [1:0] addr);
        logic bit_s;
        case (addr)
            ADDR0:   bit_s = vec[0];
            ADDR1:   bit_s = vec[1];
            ADDR2:   bit_s = vec[2];
            default: bit_s = 1'b0;
        endcase
        return bit_s;
    endfunction

    function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
        logic [2:0] oh_s;
        case (addr)
            ADDR0:   oh_s = 3'b001;
            ADDR1:   oh_s = 3'b010;
            ADDR2:   oh_s = 3'b100;
            default: oh_s = 3'b000;
        endcase
        return oh_s;
    endfunction

endpackage

// File: rtl/router_sr_timer.sv
// router_sr_timer: per-channel read-idle watchdog.
//   clock, resetn - clock and synchronous active-low reset
//   vld_out       - channel holds data
//   read_enb      - destination is reading the channel
//   soft_reset    - registered one-cycle pulse after TIMEOUT idle cycles
module router_sr_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_out,
    input  logic read_enb,
    output logic soft_reset
);

    localparam logic [4:0] TERMINAL = 5'(TIMEOUT - 1);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       soft_reset_q;
    logic       soft_reset_d;

    // Next count and pulse; a read (or no data) always clears and suppresses the pulse.
    always_comb begin
        cnt_d        = cnt_q;
        soft_reset_d = 1'b0;
        if (read_enb || !vld_out) begin
            cnt_d = 5'd0;
        end else if (cnt_q == TERMINAL) begin
            cnt_d        = 5'd0;
            soft_reset_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q        <= 5'd0;
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: packet-router control FSM.
//   clock, resetn           - clock, synchronous active-low reset
//   pkt_valid, data_in      - source handshake and byte (header [1:0] = destination)
//   parity_done, low_pkt_valid - status from the register block
//   full, empty, read_enb   - per-FIFO status and per-channel read strobes
//   write_enb, soft_reset, vld_out, fifo_full, busy - FIFO / source controls
//   detect_add .. write_enb_reg - state strobes to the register block
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] full,
    input  logic [2:0] empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic [2:0] soft_reset,
    output logic [2:0] vld_out,
    output logic       fifo_full,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] addr_q;
    logic [1:0] addr_d;
    logic [1:0] hdr_addr_s;
    logic       hdr_ok_s;
    logic       unused_hdr_s;

    assign hdr_addr_s   = data_in[1:0];
    assign hdr_ok_s     = pkt_valid && (hdr_addr_s != ADDR_INVALID);
    assign unused_hdr_s = ^data_in[7:2];

    assign vld_out   = ~empty;
    assign fifo_full = sel_bit(full, addr_q);
    assign write_enb = write_enb_reg ? addr_onehot(addr_q) : 3'b000;

    genvar ch;
    generate
        for (ch = 0; ch < 3; ch++) begin : g_timer
            router_sr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
                .clock      (clock),
                .resetn     (resetn),
                .vld_out    (vld_out[ch]),
                .read_enb   (read_enb[ch]),
                .soft_reset (soft_reset[ch])
            );
        end
    endgenerate

    // Next-state logic; a soft reset of the latched channel overrides every transition.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid) begin
            addr_d = hdr_addr_s;
        end else begin
            addr_d = addr_q;
        end
        if (sel_bit(soft_reset, addr_q)) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok_s && sel_bit(empty, hdr_addr_s)) begin
                        state_d = LOAD_FIRST_DATA;
                    end else if (hdr_ok_s) begin
                        state_d = WAIT_TILL_EMPTY;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end else begin
                        state_d = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_bit(empty, addr_q)) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // State and latched destination registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= ADDR0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Moore strobes decoded from the registered state.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            WAIT_TILL_EMPTY:    busy          = 1'b1;
            default:            busy          = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed self-checking bench for router_ctrl.
module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic [2:0] soft_reset;
    logic [2:0] vld_out;
    logic       fifo_full;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic [7:0] strobes;

    int tests_run = 0;
    int tests_failed = 0;

    // {detect_add, lfd, ld, full, laf, rst_int, write_enb_reg, busy} per state
    localparam logic [7:0] EXP_DA  = 8'b1000_0000;
    localparam logic [7:0] EXP_LFD = 8'b0100_0001;
    localparam logic [7:0] EXP_LD  = 8'b0010_0010;
    localparam logic [7:0] EXP_FF  = 8'b0001_0001;
    localparam logic [7:0] EXP_LAF = 8'b0000_1011;
    localparam logic [7:0] EXP_LP  = 8'b0000_0011;
    localparam logic [7:0] EXP_CPE = 8'b0000_0101;
    localparam logic [7:0] EXP_WTE = 8'b0000_0001;

    assign strobes = {detect_add, lfd_state, ld_state, full_state, laf_state,
                      rst_int_reg, write_enb_reg, busy};

    router_ctrl #(.TIMEOUT(30)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .full          (full),
        .empty         (empty),
        .read_enb      (read_enb),
        .write_enb     (write_enb),
        .soft_reset    (soft_reset),
        .vld_out       (vld_out),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; parity_done = 1'b0;
        low_pkt_valid = 1'b0; full = 3'b000; empty = 3'b111; read_enb = 3'b000;
        step(); step();
        resetn = 1'b1;
        #1;
        tests_run++;
        if (strobes !== EXP_DA) begin tests_failed++; $display("FAIL reset_strobes got %b want %b", strobes, EXP_DA); end
        tests_run++;
        if (write_enb !== 3'b000) begin tests_failed++; $display("FAIL reset_write_enb got %b want 000", write_enb); end
        tests_run++;
        if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL reset_soft_reset got %b want 000", soft_reset); end
        empty = 3'b110; full = 3'b001;
        #1;
        tests_run++;
        if (vld_out !== 3'b001) begin tests_failed++; $display("FAIL reset_vld_out got %b want 001", vld_out); end
        tests_run++;
        if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL reset_fifo_full got %b want 1", fifo_full); end
        empty = 3'b111; full = 3'b000;
    endtask

    task automatic test_packet();
        pkt_valid = 1'b1; data_in = 8'h0D;
        step();
        tests_run++;
        if (strobes !== EXP_LFD || write_enb !== 3'b000) begin tests_failed++; $display("FAIL pkt_lfd got %b/%b want %b/000", strobes, write_enb, EXP_LFD); end
        for (int i = 0; i < 3; i++) begin
            data_in = 8'hA1 + 8'(i);
            step();
            tests_run++;
            if (strobes !== EXP_LD || write_enb !== 3'b010) begin tests_failed++; $display("FAIL pkt_ld%0d got %b/%b want %b/010", i, strobes, write_enb, EXP_LD); end
        end
        pkt_valid = 1'b0; data_in = 8'h5C;
        step();
        tests_run++;
        if (strobes !== EXP_LP || write_enb !== 3'b010) begin tests_failed++; $display("FAIL pkt_lp got %b/%b want %b/010", strobes, write_enb, EXP_LP); end
        step();
        tests_run++;
        if (strobes !== EXP_CPE || write_enb !== 3'b000) begin tests_failed++; $display("FAIL pkt_cpe got %b/%b want %b/000", strobes, write_enb, EXP_CPE); end
        step();
        tests_run++;
        if (strobes !== EXP_DA) begin tests_failed++; $display("FAIL pkt_done got %b want %b", strobes, EXP_DA); end
    endtask

    task automatic test_wait_empty();
        empty = 3'b011; pkt_valid = 1'b1; data_in = 8'h02;
        step();
        tests_run++;
        if (strobes !== EXP_WTE || write_enb !== 3'b000) begin tests_failed++; $display("FAIL wait_enter got %b/%b want %b/000", strobes, write_enb, EXP_WTE); end
        pkt_valid = 1'b0;
        step();
        tests_run++;
        if (strobes !== EXP_WTE) begin tests_failed++; $display("FAIL wait_hold got %b want %b", strobes, EXP_WTE); end
        empty = 3'b111;
        step();
        tests_run++;
        if (strobes !== EXP_LFD) begin tests_failed++; $display("FAIL wait_release got %b want %b", strobes, EXP_LFD); end
        step(); step(); step(); step();
        tests_run++;
        if (strobes !== EXP_DA) begin tests_failed++; $display("FAIL wait_done got %b want %b", strobes, EXP_DA); end
    endtask

    task automatic test_fifo_full();
        pkt_valid = 1'b1; data_in = 8'h00;
        step(); step();
        tests_run++;
        if (strobes !== EXP_LD || write_enb !== 3'b001) begin tests_failed++; $display("FAIL full_ld got %b/%b want %b/001", strobes, write_enb, EXP_LD); end
        full = 3'b001;
        #1;
        tests_run++;
        if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL full_flag got %b want 1", fifo_full); end
        step();
        tests_run++;
        if (strobes !== EXP_FF || write_enb !== 3'b000) begin tests_failed++; $display("FAIL full_enter got %b/%b want %b/000", strobes, write_enb, EXP_FF); end
        step();
        tests_run++;
        if (strobes !== EXP_FF) begin tests_failed++; $display("FAIL full_hold got %b want %b", strobes, EXP_FF); end
        full = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step();
        tests_run++;
        if (strobes !== EXP_LAF || write_enb !== 3'b001) begin tests_failed++; $display("FAIL full_laf got %b/%b want %b/001", strobes, write_enb, EXP_LAF); end
        step();
        tests_run++;
        if (strobes !== EXP_LP) begin tests_failed++; $display("FAIL full_lp got %b want %b", strobes, EXP_LP); end
        low_pkt_valid = 1'b0; full = 3'b001;
        step(); step();
        tests_run++;
        if (strobes !== EXP_FF) begin tests_failed++; $display("FAIL cpe_to_full got %b want %b", strobes, EXP_FF); end
        full = 3'b000; parity_done = 1'b1;
        step(); step();
        tests_run++;
        if (strobes !== EXP_DA) begin tests_failed++; $display("FAIL laf_parity_done got %b want %b", strobes, EXP_DA); end
        parity_done = 1'b0;
    endtask

    task automatic test_invalid_and_reset();
        pkt_valid = 1'b1; data_in = 8'h03;
        step();
        tests_run++;
        if (strobes !== EXP_DA || write_enb !== 3'b000) begin tests_failed++; $display("FAIL invalid_addr got %b/%b want %b/000", strobes, write_enb, EXP_DA); end
        data_in = 8'h01;
        step(); step();
        tests_run++;
        if (strobes !== EXP_LD || write_enb !== 3'b010) begin tests_failed++; $display("FAIL midpkt_ld got %b/%b want %b/010", strobes, write_enb, EXP_LD); end
        resetn = 1'b0;
        step();
        tests_run++;
        if (strobes !== EXP_DA || write_enb !== 3'b000) begin tests_failed++; $display("FAIL midpkt_reset got %b/%b want %b/000", strobes, write_enb, EXP_DA); end
        resetn = 1'b1; pkt_valid = 1'b0;
        step();
        tests_run++;
        if (strobes !== EXP_DA || write_enb !== 3'b000) begin tests_failed++; $display("FAIL post_reset got %b/%b want %b/000", strobes, write_enb, EXP_DA); end
    endtask

    task automatic test_timeout();
        pkt_valid = 1'b1; data_in = 8'h01;
        step(); step();
        empty = 3'b101;
        for (int i = 1; i <= 29; i++) begin
            step();
            tests_run++;
            if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL timeout_early cycle %0d got %b want 000", i, soft_reset); end
        end
        step();
        tests_run++;
        if (soft_reset !== 3'b010 || strobes !== EXP_LD) begin tests_failed++; $display("FAIL timeout_pulse got %b/%b want 010/%b", soft_reset, strobes, EXP_LD); end
        step();
        tests_run++;
        if (soft_reset !== 3'b000 || strobes !== EXP_DA) begin tests_failed++; $display("FAIL timeout_after got %b/%b want 000/%b", soft_reset, strobes, EXP_DA); end
        empty = 3'b111; pkt_valid = 1'b0;
        step();
    endtask

    task automatic test_read_wins();
        empty = 3'b110;
        for (int i = 1; i <= 29; i++) begin
            step();
            tests_run++;
            if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL read_pre cycle %0d got %b want 000", i, soft_reset); end
        end
        read_enb = 3'b001;
        step();
        tests_run++;
        if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL read_wins got %b want 000", soft_reset); end
        read_enb = 3'b000;
        for (int i = 1; i <= 29; i++) begin
            step();
            tests_run++;
            if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL read_post cycle %0d got %b want 000", i, soft_reset); end
        end
        step();
        tests_run++;
        if (soft_reset !== 3'b001) begin tests_failed++; $display("FAIL read_restart_pulse got %b want 001", soft_reset); end
        empty = 3'b111;
        step();
        tests_run++;
        if (soft_reset !== 3'b000) begin tests_failed++; $display("FAIL read_pulse_end got %b want 000", soft_reset); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_wait_empty();
        test_fifo_full();
        test_invalid_and_reset();
        test_timeout();
        test_read_wins();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
